// File: rtl/slice_ar_arbiter.sv
// Round-robin arbiter merging per-slice AR requests onto one master AR channel,
// with per-slice outstanding-burst tracking used to route R beats back by ID.
module slice_ar_arbiter #(
  parameter int NUM_SLICES      = 4,
  parameter int ADDR_BITS       = 64,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int TID_WIDTH       = 8,
  parameter int MAX_OUTST       = 15
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_SLICES-1:0]                 sl_ar_valid,
  output logic [NUM_SLICES-1:0]                 sl_ar_ready,
  input  logic [NUM_SLICES*ADDR_BITS-1:0]       sl_ar_addr,
  input  logic [NUM_SLICES*BURST_LEN_WIDTH-1:0] sl_ar_len,
  input  logic [NUM_SLICES*TID_WIDTH-1:0]       sl_ar_id,
  output logic                                  m_ar_valid,
  input  logic                                  m_ar_ready,
  output logic [ADDR_BITS-1:0]                  m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0]            m_ar_len,
  output logic [TID_WIDTH-1:0]                  m_ar_id,
  input  logic                                  m_r_valid,
  input  logic                                  m_r_last,
  input  logic [TID_WIDTH-1:0]                  m_r_id,
  output logic                                  m_r_ready,
  output logic [NUM_SLICES-1:0]                 sl_r_valid,
  input  logic [NUM_SLICES-1:0]                 sl_r_ready,
  output logic [NUM_SLICES-1:0]                 sl_busy,
  output logic                                  r_orphan
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int PTR_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t               state;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     hold_idx;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     r_sel;
  logic [CNT_W-1:0]     cnt      [NUM_SLICES];
  logic [TID_WIDTH-1:0] owner_id [NUM_SLICES];
  logic [NUM_SLICES-1:0] eligible;
  logic                 grant_found;
  logic                 r_match;
  logic                 ar_done;
  logic                 r_done;

  // A slice with bursts in flight may only add more under the same ID, so
  // every outstanding burst of a slice shares the ID used for R routing.
  always_comb begin
    for (int i = 0; i < NUM_SLICES; i++) begin
      eligible[i] = sl_ar_valid[i] && (cnt[i] < CNT_W'(MAX_OUTST)) &&
                    ((cnt[i] == '0) || (sl_ar_id[i*TID_WIDTH +: TID_WIDTH] == owner_id[i]));
      sl_busy[i]  = (cnt[i] != '0);
    end
  end

  always_comb begin
    logic [PTR_W:0] idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = 0; k < NUM_SLICES; k++) begin
      idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(NUM_SLICES))
        idx = idx - (PTR_W+1)'(NUM_SLICES);
      if (!grant_found && eligible[idx[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    sl_ar_ready = '0;
    if (state == ST_IDLE && grant_found)
      sl_ar_ready[grant_idx] = 1'b1;
  end

  // Beats with no owning slice are accepted and discarded so the master never stalls.
  always_comb begin
    r_match    = 1'b0;
    r_sel      = '0;
    for (int i = NUM_SLICES - 1; i >= 0; i--) begin
      if (cnt[i] != '0 && owner_id[i] == m_r_id) begin
        r_match = 1'b1;
        r_sel   = PTR_W'(i);
      end
    end
    sl_r_valid = '0;
    m_r_ready  = 1'b1;
    if (r_match) begin
      sl_r_valid[r_sel] = m_r_valid;
      m_r_ready         = sl_r_ready[r_sel];
    end
  end

  assign ar_done = m_ar_valid && m_ar_ready;
  assign r_done  = m_r_valid && m_r_ready && m_r_last && r_match;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      hold_idx   <= '0;
      m_ar_valid <= 1'b0;
      m_ar_addr  <= '0;
      m_ar_len   <= '0;
      m_ar_id    <= '0;
      r_orphan   <= 1'b0;
      for (int i = 0; i < NUM_SLICES; i++) begin
        cnt[i]      <= '0;
        owner_id[i] <= '0;
      end
    end else begin
      r_orphan <= m_r_valid && !r_match;
      for (int i = 0; i < NUM_SLICES; i++) begin
        if ((ar_done && hold_idx == PTR_W'(i)) && !(r_done && r_sel == PTR_W'(i)))
          cnt[i] <= cnt[i] + 1'b1;
        else if ((r_done && r_sel == PTR_W'(i)) && !(ar_done && hold_idx == PTR_W'(i)))
          cnt[i] <= cnt[i] - 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (grant_found) begin
            m_ar_addr           <= sl_ar_addr[grant_idx*ADDR_BITS +: ADDR_BITS];
            m_ar_len            <= sl_ar_len[grant_idx*BURST_LEN_WIDTH +: BURST_LEN_WIDTH];
            m_ar_id             <= sl_ar_id[grant_idx*TID_WIDTH +: TID_WIDTH];
            owner_id[grant_idx] <= sl_ar_id[grant_idx*TID_WIDTH +: TID_WIDTH];
            m_ar_valid          <= 1'b1;
            hold_idx            <= grant_idx;
            state               <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (m_ar_ready) begin
            m_ar_valid <= 1'b0;
            rr_ptr     <= (hold_idx == PTR_W'(NUM_SLICES - 1)) ? '0 : hold_idx + 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slice_ar_arbiter.sv
// Self-checking bench for slice_ar_arbiter: a vector table, directed corner
// sequences, and randomized traffic against a transaction-level reference model.
module tb_slice_ar_arbiter;

  localparam int N    = 4;
  localparam int AW   = 64;
  localparam int LW   = 8;
  localparam int TW   = 8;
  localparam int MAXO = 15;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    sl_ar_valid, sl_ar_ready;
  logic [N*AW-1:0] sl_ar_addr;
  logic [N*LW-1:0] sl_ar_len;
  logic [N*TW-1:0] sl_ar_id;
  logic            m_ar_valid, m_ar_ready;
  logic [AW-1:0]   m_ar_addr;
  logic [LW-1:0]   m_ar_len;
  logic [TW-1:0]   m_ar_id;
  logic            m_r_valid, m_r_last, m_r_ready;
  logic [TW-1:0]   m_r_id;
  logic [N-1:0]    sl_r_valid, sl_r_ready, sl_busy;
  logic            r_orphan;

  always #5 clk = ~clk;

  slice_ar_arbiter #(.NUM_SLICES(N), .ADDR_BITS(AW), .BURST_LEN_WIDTH(LW),
                     .TID_WIDTH(TW), .MAX_OUTST(MAXO)) dut (
    .clk(clk), .reset(reset),
    .sl_ar_valid(sl_ar_valid), .sl_ar_ready(sl_ar_ready),
    .sl_ar_addr(sl_ar_addr), .sl_ar_len(sl_ar_len), .sl_ar_id(sl_ar_id),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
    .m_r_valid(m_r_valid), .m_r_last(m_r_last), .m_r_id(m_r_id), .m_r_ready(m_r_ready),
    .sl_r_valid(sl_r_valid), .sl_r_ready(sl_r_ready),
    .sl_busy(sl_busy), .r_orphan(r_orphan)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: outstanding bursts per slice, their owner ID, and the
  // single AR currently offered to the master.
  int            mdl_cnt   [N];
  logic [TW-1:0] mdl_owner [N];
  bit            mdl_hold;
  int            mdl_g;
  int            mdl_rr;
  bit            mdl_orphan;
  logic [AW-1:0] mdl_addr;
  logic [LW-1:0] mdl_len;
  logic [TW-1:0] mdl_id;

  typedef struct {
    logic [N-1:0]  valid;
    logic          mready;
    logic [N-1:0]  exp_ready;
    logic          exp_mvalid;
    logic [TW-1:0] exp_id;
  } vec_t;

  vec_t vecs [9];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic setSlice(input int i, input logic [TW-1:0] id, input logic [AW-1:0] addr,
                          input logic [LW-1:0] len);
    sl_ar_id[i*TW +: TW]   = id;
    sl_ar_addr[i*AW +: AW] = addr;
    sl_ar_len[i*LW +: LW]  = len;
  endtask

  task automatic doReset;
    reset       = 1'b1;
    sl_ar_valid = '0;
    m_ar_ready  = 1'b0;
    m_r_valid   = 1'b0;
    m_r_last    = 1'b0;
    m_r_id      = '0;
    sl_r_ready  = '1;
    @(negedge clk);
    #1;
    checkOutput("rst_m_ar_valid", 64'(m_ar_valid), 0);
    checkOutput("rst_m_ar_addr", 64'(m_ar_addr), 0);
    checkOutput("rst_sl_busy", 64'(sl_busy), 0);
    checkOutput("rst_r_orphan", 64'(r_orphan), 0);
    checkOutput("rst_sl_ar_ready", 64'(sl_ar_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      mdl_cnt[i]   = 0;
      mdl_owner[i] = '0;
    end
    mdl_hold   = 0;
    mdl_g      = 0;
    mdl_rr     = 0;
    mdl_orphan = 0;
    mdl_addr   = '0;
    mdl_len    = '0;
    mdl_id     = '0;
  endtask

  task automatic applyStimulus(input bit heavy_last);
    int sel;
    sl_ar_valid = N'($urandom);
    for (int i = 0; i < N; i++)
      setSlice(i, TW'($urandom_range(1, 3)), {$urandom, $urandom}, LW'($urandom));
    m_ar_ready = ($urandom_range(0, 3) != 0);
    m_r_valid  = ($urandom_range(0, 1) == 1);
    sel        = int'($urandom_range(0, 3));
    m_r_id     = (sel == 3) ? TW'(8'h1F) : TW'(sel + 1);
    m_r_last   = heavy_last ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
    sl_r_ready = N'($urandom);
  endtask

  // Compare the DUT against the model for the current cycle, then advance the
  // model across the coming clock edge.
  task automatic modelCycle;
    int           grant;
    int           sel;
    int           j;
    logic [N-1:0] exp_ready, exp_rvalid, exp_busy;
    logic         exp_rready;
    bit           elig;
    grant = -1;
    sel   = -1;
    exp_ready  = '0;
    exp_rvalid = '0;
    exp_busy   = '0;
    if (!mdl_hold) begin
      for (int k = 0; k < N; k++) begin
        j    = (mdl_rr + k) % N;
        elig = sl_ar_valid[j] && (mdl_cnt[j] < MAXO) &&
               (mdl_cnt[j] == 0 || sl_ar_id[j*TW +: TW] == mdl_owner[j]);
        if (grant < 0 && elig) grant = j;
      end
    end
    if (grant >= 0) exp_ready[grant] = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (sel < 0 && mdl_cnt[i] > 0 && mdl_owner[i] == m_r_id) sel = i;
      exp_busy[i] = (mdl_cnt[i] > 0);
    end
    exp_rready = 1'b1;
    if (sel >= 0) begin
      exp_rvalid[sel] = m_r_valid;
      exp_rready      = sl_r_ready[sel];
    end
    checkOutput("rnd_sl_ar_ready", 64'(sl_ar_ready), 64'(exp_ready));
    checkOutput("rnd_m_ar_valid", 64'(m_ar_valid), 64'(mdl_hold));
    if (mdl_hold) begin
      checkOutput("rnd_m_ar_addr", 64'(m_ar_addr), 64'(mdl_addr));
      checkOutput("rnd_m_ar_len", 64'(m_ar_len), 64'(mdl_len));
      checkOutput("rnd_m_ar_id", 64'(m_ar_id), 64'(mdl_id));
    end
    checkOutput("rnd_sl_r_valid", 64'(sl_r_valid), 64'(exp_rvalid));
    checkOutput("rnd_m_r_ready", 64'(m_r_ready), 64'(exp_rready));
    checkOutput("rnd_sl_busy", 64'(sl_busy), 64'(exp_busy));
    checkOutput("rnd_r_orphan", 64'(r_orphan), 64'(mdl_orphan));

    mdl_orphan = m_r_valid && (sel < 0);
    if (sel >= 0 && m_r_valid && sl_r_ready[sel] && m_r_last) mdl_cnt[sel]--;
    if (mdl_hold) begin
      if (m_ar_ready) begin
        mdl_cnt[mdl_g]++;
        mdl_rr   = (mdl_g + 1) % N;
        mdl_hold = 0;
      end
    end else if (grant >= 0) begin
      mdl_addr         = sl_ar_addr[grant*AW +: AW];
      mdl_len          = sl_ar_len[grant*LW +: LW];
      mdl_id           = sl_ar_id[grant*TW +: TW];
      mdl_owner[grant] = mdl_id;
      mdl_hold         = 1;
      mdl_g            = grant;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int grants;
    sl_ar_addr = '0;
    sl_ar_len  = '0;
    sl_ar_id   = '0;

    // All four slices requesting continuously: one AR every two cycles, in turn.
    vecs[0] = '{4'b1111, 1'b1, 4'b0001, 1'b0, 8'h00};
    vecs[1] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 8'h01};
    vecs[2] = '{4'b1111, 1'b1, 4'b0010, 1'b0, 8'h00};
    vecs[3] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 8'h02};
    vecs[4] = '{4'b1111, 1'b1, 4'b0100, 1'b0, 8'h00};
    vecs[5] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 8'h03};
    vecs[6] = '{4'b1111, 1'b1, 4'b1000, 1'b0, 8'h00};
    vecs[7] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 8'h04};
    vecs[8] = '{4'b1111, 1'b1, 4'b0001, 1'b0, 8'h00};

    doReset();
    for (int i = 0; i < N; i++)
      setSlice(i, TW'(i + 1), AW'(64'h1000 * (i + 1)), LW'(i));
    for (int v = 0; v < 9; v++) begin
      sl_ar_valid = vecs[v].valid;
      m_ar_ready  = vecs[v].mready;
      #1;
      checkOutput("tbl_sl_ar_ready", 64'(sl_ar_ready), 64'(vecs[v].exp_ready));
      checkOutput("tbl_m_ar_valid", 64'(m_ar_valid), 64'(vecs[v].exp_mvalid));
      if (vecs[v].exp_mvalid)
        checkOutput("tbl_m_ar_id", 64'(m_ar_id), 64'(vecs[v].exp_id));
      step();
    end

    // Master back-pressure holds the AR stable; then an unowned R beat is dropped.
    doReset();
    setSlice(1, 8'h05, 64'hDEAD_BEEF_0000_1100, 8'h07);
    sl_ar_valid = 4'b0010;
    m_ar_ready  = 1'b0;
    #1;
    checkOutput("hold_grant", 64'(sl_ar_ready), 'h2);
    step();
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput("hold_m_ar_valid", 64'(m_ar_valid), 1);
      checkOutput("hold_m_ar_addr", 64'(m_ar_addr), 64'hDEAD_BEEF_0000_1100);
      checkOutput("hold_sl_ar_ready", 64'(sl_ar_ready), 0);
      step();
    end
    m_ar_ready  = 1'b1;
    sl_ar_valid = '0;
    step();
    #1;
    checkOutput("hold_done_valid", 64'(m_ar_valid), 0);
    checkOutput("hold_done_busy", 64'(sl_busy), 'h2);
    step();
    m_r_valid = 1'b1;
    m_r_last  = 1'b1;
    m_r_id    = 8'h1F;
    #1;
    checkOutput("orphan_m_r_ready", 64'(m_r_ready), 1);
    checkOutput("orphan_sl_r_valid", 64'(sl_r_valid), 0);
    checkOutput("orphan_not_yet", 64'(r_orphan), 0);
    step();
    m_r_valid = 1'b0;
    #1;
    checkOutput("orphan_pulse", 64'(r_orphan), 1);
    checkOutput("orphan_busy", 64'(sl_busy), 'h2);
    step();
    #1;
    checkOutput("orphan_pulse_end", 64'(r_orphan), 0);

    // Saturation at the outstanding limit, released by one completed burst.
    doReset();
    setSlice(2, 8'h22, 64'h2200, 8'h03);
    sl_ar_valid = 4'b0100;
    m_ar_ready  = 1'b1;
    grants      = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (sl_ar_ready[2]) grants++;
      step();
    end
    checkOutput("sat_grant_count", 64'(grants), MAXO);
    checkOutput("sat_busy", 64'(sl_busy), 'h4);
    m_r_valid = 1'b1;
    m_r_last  = 1'b1;
    m_r_id    = 8'h22;
    #1;
    checkOutput("sat_blocked", 64'(sl_ar_ready), 0);
    checkOutput("sat_r_route", 64'(sl_r_valid), 'h4);
    step();
    m_r_valid = 1'b0;
    #1;
    checkOutput("sat_release", 64'(sl_ar_ready), 'h4);

    // An ID change waits until the slice's earlier bursts have all completed.
    doReset();
    setSlice(0, 8'h03, 64'h0300, 8'h01);
    sl_ar_valid = 4'b0001;
    m_ar_ready  = 1'b1;
    repeat (4) step();
    setSlice(0, 8'h07, 64'h0700, 8'h02);
    #1;
    checkOutput("idchg_blocked", 64'(sl_ar_ready), 0);
    checkOutput("idchg_busy", 64'(sl_busy), 'h1);
    step();
    m_r_valid = 1'b1;
    m_r_last  = 1'b1;
    m_r_id    = 8'h03;
    #1;
    checkOutput("idchg_r_route", 64'(sl_r_valid), 'h1);
    checkOutput("idchg_blocked2", 64'(sl_ar_ready), 0);
    step();
    #1;
    checkOutput("idchg_blocked3", 64'(sl_ar_ready), 0);
    step();
    m_r_valid = 1'b0;
    #1;
    checkOutput("idchg_granted", 64'(sl_ar_ready), 'h1);
    step();
    #1;
    checkOutput("idchg_m_ar_valid", 64'(m_ar_valid), 1);
    checkOutput("idchg_m_ar_id", 64'(m_ar_id), 'h07);
    sl_ar_valid = '0;
    step();

    // AR handshake and R last beat for the same slice in the same cycle.
    doReset();
    setSlice(3, 8'h09, 64'h0900, 8'h04);
    sl_ar_valid = 4'b1000;
    m_ar_ready  = 1'b1;
    repeat (3) step();
    sl_ar_valid = '0;
    m_r_valid   = 1'b1;
    m_r_last    = 1'b1;
    m_r_id      = 8'h09;
    #1;
    checkOutput("same_m_ar_valid", 64'(m_ar_valid), 1);
    checkOutput("same_r_route", 64'(sl_r_valid), 'h8);
    step();
    #1;
    checkOutput("same_busy_kept", 64'(sl_busy), 'h8);
    step();
    m_r_valid = 1'b0;
    #1;
    checkOutput("same_busy_drained", 64'(sl_busy), 0);

    // Asynchronous reset while an AR is pending; later R beats become orphans.
    sl_ar_valid = 4'b1000;
    m_ar_ready  = 1'b1;
    repeat (2) step();
    m_ar_ready = 1'b0;
    step();
    #1;
    checkOutput("arst_pending", 64'(m_ar_valid), 1);
    checkOutput("arst_busy_before", 64'(sl_busy), 'h8);
    reset = 1'b1;
    #1;
    checkOutput("arst_m_ar_valid", 64'(m_ar_valid), 0);
    checkOutput("arst_busy", 64'(sl_busy), 0);
    @(negedge clk);
    reset       = 1'b0;
    sl_ar_valid = '0;
    m_r_valid   = 1'b1;
    m_r_last    = 1'b1;
    m_r_id      = 8'h09;
    #1;
    checkOutput("arst_r_drop", 64'(sl_r_valid), 0);
    checkOutput("arst_r_ready", 64'(m_r_ready), 1);
    step();
    m_r_valid = 1'b0;
    #1;
    checkOutput("arst_orphan", 64'(r_orphan), 1);

    // Randomized traffic against the reference model.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(c >= 1500);
      #1;
      modelCycle();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/slice_ar_arbiter.md
SLICE_AR_ARBITER -- requirements
Module: slice_ar_arbiter

Interface
REQ-001 Parameter NUM_SLICES, default 4, number of prefetcher slices sharing one master AR/R channel pair.
REQ-002 Parameter ADDR_BITS, default 64, address width.
REQ-003 Parameter BURST_LEN_WIDTH, default 8, AR len width.
REQ-004 Parameter TID_WIDTH, default 8, transaction ID width.
REQ-005 Parameter MAX_OUTST, default 15, per-slice outstanding-burst limit; counter width = clog2(MAX_OUTST+1).
REQ-006 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-007 clk  in  1  clock, all state on rising edge.
REQ-008 reset  in  1  asynchronous active-high reset.
REQ-009 sl_ar_valid / sl_ar_ready  in / out  NUM_SLICES  per-slice AR handshake; bit i = slice i.
REQ-010 sl_ar_addr / sl_ar_len / sl_ar_id  in  NUM_SLICES*ADDR_BITS / *BURST_LEN_WIDTH / *TID_WIDTH  per-slice AR payload, slice i in field i.
REQ-011 m_ar_valid / m_ar_ready  out / in  1  master AR handshake.
REQ-012 m_ar_addr / m_ar_len / m_ar_id  out  ADDR_BITS / BURST_LEN_WIDTH / TID_WIDTH  master AR payload.
REQ-013 m_r_valid, m_r_last / m_r_ready  in / out  1  master R handshake; m_r_id in TID_WIDTH.
REQ-014 sl_r_valid / sl_r_ready  out / in  NUM_SLICES  per-slice routed R handshake.
REQ-015 sl_busy  out  NUM_SLICES  bit i = slice i outstanding count nonzero.
REQ-016 r_orphan  out  1  registered one-cycle pulse: R beat with no owning slice was dropped.

Function
REQ-017 Arbitration FSM SHALL have states ST_IDLE and ST_HOLD.
REQ-018 eligible[i] = sl_ar_valid[i] & (cnt[i] < MAX_OUTST) & (cnt[i]==0 | sl_ar_id[i]==owner_id[i]).
REQ-019 In ST_IDLE with any eligible bit, grant g = first eligible index searching upward from rr_ptr with wrap at NUM_SLICES; sl_ar_ready[g]=1 combinationally that cycle, all other sl_ar_ready=0.
REQ-020 On grant: m_ar_addr/len/id <= slice g payload, owner_id[g] <= sl_ar_id[g], m_ar_valid <= 1, state -> ST_HOLD; m_ar_valid rises exactly 1 cycle after the slice handshake.
REQ-021 In ST_HOLD all sl_ar_ready SHALL be 0 and m_ar_* SHALL be stable until m_ar_valid & m_ar_ready.
REQ-022 On m_ar_valid & m_ar_ready: m_ar_valid <= 0, cnt[g]++, rr_ptr <= (g+1) mod NUM_SLICES, state -> ST_IDLE; no grant in that cycle (max one AR per 2 cycles).
REQ-023 R routing (combinational): sel = lowest i with cnt[i]!=0 & owner_id[i]==m_r_id; sl_r_valid[sel]=m_r_valid, others 0; m_r_ready = sl_r_ready[sel].
REQ-024 No matching slice: m_r_ready=1 (beat dropped), no sl_r_valid asserted, r_orphan=1 next cycle.
REQ-025 On m_r_valid & m_r_ready & m_r_last with match: cnt[sel]--.
REQ-026 Same-cycle increment and decrement of one slice SHALL leave cnt unchanged.
REQ-027 cnt SHALL never exceed MAX_OUTST nor go below 0 (decrement only on match, which implies cnt!=0).
REQ-028 Slice presenting a different ID while cnt!=0 SHALL stay ineligible until cnt returns to 0 (routing integrity).
REQ-029 Non-eligible slices SHALL not affect rr_ptr.

Reset
REQ-030 On reset: state ST_IDLE, rr_ptr 0, all cnt 0, owner_id 0, m_ar_valid 0, m_ar_addr/len/id 0, r_orphan 0; therefore sl_ar_ready, sl_r_valid, sl_busy all 0.
REQ-031 Reset asserted mid-ST_HOLD SHALL drop the pending AR and clear counters immediately (asynchronous); in-flight R beats after release are orphans.

Verification
REQ-032 All four slices valid from reset, m_ar_ready=1 -> grants 0,1,2,3,0 on cycles 0,2,4,6,8; m_ar_valid high cycles 1,3,5,7.
REQ-033 Slice 1 id 0x05, m_ar_ready held 0 for 5 cycles -> m_ar_valid high and m_ar_addr stable all 5 cycles, no sl_ar_ready, cnt[1]=1 after ready.
REQ-034 Slice 2 cnt=MAX_OUTST=15 with valid -> never granted; one R last beat with id=owner_id[2] -> cnt 14, granted next eligible IDLE cycle.
REQ-035 Slice 0 cnt=2 id 0x03 presents id 0x07 -> not granted; two R last beats id 0x03 -> cnt 0, then granted, owner_id[0]=0x07.
REQ-036 m_r_valid with m_r_id=0x1F matching no slice -> m_r_ready=1, sl_r_valid=0, r_orphan pulse 1 cycle later, counters unchanged.
REQ-037 Slice 3 m_ar handshake and its R last beat in same cycle -> cnt[3] unchanged, sl_busy[3] unchanged.
